wavetable_interp: RTL and testbench
===================================

WAVETABLE_INTERP -- requirements
Module: wavetable_interp

Interface
REQ-001 SHALL provide parameter AW, default 12: wavetable address width, giving 2^AW entries.
REQ-002 SHALL provide parameter IW, default 20: width of the incoming phase fraction.
REQ-003 SHALL provide parameter OW, default 16: signed sample width.
REQ-004 SHALL provide parameter FW, default 10: interpolation weight width, taken from interp[IW-1:IW-FW], with 1 <= FW <= IW.
REQ-005 SHALL provide port Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL provide port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL provide port in_valid, input, 1 bit: wavetable_addr and interp are valid this cycle.
REQ-008 SHALL provide port wavetable_addr, input, AW bits: table index from the upstream phasor.
REQ-009 SHALL provide port interp, input, IW bits: fractional position between entries.
REQ-010 SHALL provide port wt_we, input, 1 bit: table write enable.
REQ-011 SHALL provide port wt_waddr, input, AW bits: table write address.
REQ-012 SHALL provide port wt_wdata, input, OW bits (signed): table write data.
REQ-013 SHALL provide port out_valid, output, 1 bit: sample_out is valid.
REQ-014 SHALL provide port sample_out, output, OW bits (signed): interpolated sample.

Function
REQ-015 SHALL hold a 2^AW x OW internal table with synchronous write and read-first behaviour: a same-cycle read of an address being written returns the old data.
REQ-016 SHALL be a four-stage pipeline:
- S1: register addr, addr+1 (mod 2^AW), and frac.
- S2: synchronous read of s0 = table[addr] and s1 = table[addr+1].
- S3: register product p = (s1 - s0) * frac, with the (OW+1)-bit signed difference and frac zero-extended.
- S4: register sample_out = s0 + (p >>> FW).
REQ-017 SHALL assert out_valid exactly 4 cycles after the in_valid cycle it corresponds to; latency is fixed and does not depend on the data.
REQ-018 SHALL accept one input per cycle with no backpressure; back-to-back inputs produce back-to-back outputs in order.
REQ-019 SHALL advance the valid pipeline every cycle; cycles with in_valid=0 create bubbles that propagate to out_valid=0.
REQ-020 SHALL hold sample_out at its last value while out_valid=0.
REQ-021 SHALL use an arithmetic shift (floor toward -inf) for >>>; the result lies in [min(s0,s1), max(s0,s1)] and therefore never overflows OW.
REQ-022 SHALL wrap addr+1 from 2^AW-1 to 0.
REQ-023 SHALL ignore interp bits below IW-FW.
REQ-024 SHALL make a table write visible to reads issued in S2 on any later cycle.

Reset
REQ-025 SHALL, with Reset_n low, immediately force all valid flags, out_valid, and sample_out to 0, and clear all pipeline data registers to 0.
REQ-026 SHALL discard in-flight samples on reset; after Reset_n rises, out_valid stays 0 until 4 cycles after the next in_valid.
REQ-027 SHALL leave table contents unaffected by reset.
REQ-028 SHALL ignore wt_we while Reset_n is low.

Configuration
REQ-029 SHALL compute linear interpolation per REQ-016 when WAVETABLE_LINEAR_INTERP_EN is defined.
REQ-030 SHALL, when WAVETABLE_LINEAR_INTERP_EN is undefined:
- output sample_out = table[addr] (nearest-lower sample);
- omit the addr+1 read and the multiplier;
- keep the 4-cycle latency and all valid behaviour unchanged.

Verification (AW=12, IW=20, OW=16, FW=10, macro defined unless stated)
REQ-031 SHALL cover midpoint: table[5]=1000, table[6]=2000, addr=5, interp=0x80000 -> sample_out=1500 with out_valid high exactly 4 cycles later.
REQ-032 SHALL cover wrap: table[4095]=-100, table[0]=300, addr=4095, interp=0x40000 -> sample_out=0.
REQ-033 SHALL cover floor on negative slope: table[7]=10, table[8]=7, addr=7, interp=0x80000 -> sample_out=8.
REQ-034 SHALL cover throughput and reset: 8 consecutive valid inputs -> 8 consecutive in-order outputs; Reset_n low with 3 samples in flight -> out_valid=0 and sample_out=0 at once, and no outputs after release.
REQ-035 SHALL cover read-first: wt_we writing table[5]=-5 in the same cycle as the S2 read of addr 5 -> the old value is used; the next access uses -5.
REQ-036 SHALL cover the macro undefined: REQ-031 stimulus -> sample_out=1000 at the same 4-cycle latency.

Source files
------------

// File: rtl/wavetable_interp.sv
// wavetable_interp: 4-stage wavetable lookup with optional linear interpolation between adjacent entries.
// Define WAVETABLE_LINEAR_INTERP_EN for interpolation; otherwise the nearest-lower entry is output.
module wavetable_interp #(
    parameter int AW = 12,
    parameter int IW = 20,
    parameter int OW = 16,
    parameter int FW = 10
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          in_valid,
    input  logic [AW-1:0] wavetable_addr,
    input  logic [IW-1:0] interp,
    input  logic          wt_we,
    input  logic [AW-1:0] wt_waddr,
    input  logic [OW-1:0] wt_wdata,
    output logic          out_valid,
    output logic [OW-1:0] sample_out
);
    logic [OW-1:0] table_mem [2**AW];
    logic [AW-1:0] a0_1;
    logic          v1, v2, v3;
    logic [OW-1:0] s0_2, s0_3;
    logic          unused_interp;

    assign unused_interp = ^interp;

    // Nonblocking write gives read-first behaviour against the S2 read on the same edge
    always_ff @(posedge Clk) begin
        if (wt_we && Reset_n) table_mem[wt_waddr] <= wt_wdata;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {v1, v2, v3, out_valid} <= '0;
        end else begin
            {v1, v2, v3, out_valid} <= {in_valid, v1, v2, v3};
        end
    end

`ifdef WAVETABLE_LINEAR_INTERP_EN
    localparam int PW = OW + FW + 2;
    logic [AW-1:0]        a1_1;
    logic [FW-1:0]        f1, f2;
    logic [OW-1:0]        s1_2;
    logic signed [OW:0]   diff;
    logic signed [FW:0]   frac_ext;
    logic signed [PW-1:0] prod, p3;

    assign diff     = {s1_2[OW-1], s1_2} - {s0_2[OW-1], s0_2};
    assign frac_ext = {1'b0, f2};
    assign prod     = PW'(diff) * PW'(frac_ext);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a0_1       <= '0;
            a1_1       <= '0;
            f1         <= '0;
            f2         <= '0;
            s0_2       <= '0;
            s1_2       <= '0;
            s0_3       <= '0;
            p3         <= '0;
            sample_out <= '0;
        end else begin
            a0_1 <= wavetable_addr;
            a1_1 <= wavetable_addr + AW'(1);
            f1   <= interp[IW-1:IW-FW];
            s0_2 <= table_mem[a0_1];
            s1_2 <= table_mem[a1_1];
            f2   <= f1;
            s0_3 <= s0_2;
            p3   <= prod;
            // Interpolant lies between s0 and s1, so OW-bit wraparound arithmetic is exact
            if (v3) sample_out <= s0_3 + OW'(p3 >>> FW);
        end
    end
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a0_1       <= '0;
            s0_2       <= '0;
            s0_3       <= '0;
            sample_out <= '0;
        end else begin
            a0_1 <= wavetable_addr;
            s0_2 <= table_mem[a0_1];
            s0_3 <= s0_2;
            if (v3) sample_out <= s0_3;
        end
    end
`endif
endmodule

// File: tb/tb_wavetable_interp.sv
// tb_wavetable_interp: randomized and directed checks of wavetable_interp against a shadow-table model.
// Expectations follow WAVETABLE_LINEAR_INTERP_EN the same way the design does.
module tb_wavetable_interp;
    localparam int AW = 12;
    localparam int IW = 20;
    localparam int OW = 16;
    localparam int FW = 10;
    localparam int N  = 1 << AW;

    logic          Clk = 0;
    logic          Reset_n = 0;
    logic          in_valid = 0;
    logic [AW-1:0] wavetable_addr = '0;
    logic [IW-1:0] interp = '0;
    logic          wt_we = 0;
    logic [AW-1:0] wt_waddr = '0;
    logic [OW-1:0] wt_wdata = '0;
    logic          out_valid;
    logic [OW-1:0] sample_out;

    int mdl [N];
    int hv[$], hs[$];
    int last_out = 0;
    int checks = 0, fails = 0;

    wavetable_interp #(.AW(AW), .IW(IW), .OW(OW), .FW(FW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid),
        .wavetable_addr(wavetable_addr), .interp(interp),
        .wt_we(wt_we), .wt_waddr(wt_waddr), .wt_wdata(wt_wdata),
        .out_valid(out_valid), .sample_out(sample_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_sample(input int a, input int fr);
        int s0, s1, f, num, q;
        s0 = mdl[a];
        s1 = mdl[(a + 1) % N];
        f = fr >> (IW - FW);
        num = (s1 - s0) * f;
        q = num / (1 << FW);
        if (num < 0 && q * (1 << FW) != num) q--;
`ifdef WAVETABLE_LINEAR_INTERP_EN
        return s0 + q;
`else
        return s0 + 0 * q * s1;
`endif
    endfunction

    task automatic step(input bit v, input int a, input int fr, input bit we, input int wa, input int wd);
        logic signed [OW-1:0] d;
        in_valid = v;
        wavetable_addr = AW'(a);
        interp = IW'(fr);
        wt_we = we;
        wt_waddr = AW'(wa);
        wt_wdata = OW'(wd);
        d = OW'(wd);
        if (we) mdl[wa] = int'(d);
        hv.push_back(int'(v));
        hs.push_back(v ? ref_sample(a, fr) : 0);
        @(posedge Clk);
        #1;
        if (hs.size() > 3) begin
            int ev, es;
            ev = hv.pop_front();
            es = hs.pop_front();
            if (ev != 0) last_out = es;
            check("out_valid", int'(out_valid), ev);
            check("sample_out", int'($signed(sample_out)), last_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic prime();
        hv.delete();
        hs.delete();
        last_out = 0;
        for (int i = 0; i < 3; i++) begin
            hv.push_back(0);
            hs.push_back(0);
        end
    endtask

    initial begin
        #2;
        check("reset_valid", int'(out_valid), 0);
        check("reset_sample", int'($signed(sample_out)), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1;
        prime();

        for (int i = 0; i < N; i++) step(0, 0, 0, 1, i, int'($urandom_range(65535)) - 32768);

        step(0, 0, 0, 1, 5, 1000);
        step(0, 0, 0, 1, 6, 2000);
        step(1, 5, 'h80000, 0, 0, 0);
        idle(2);
        check("mid_valid_early", int'(out_valid), 0);
        idle(1);
        check("mid_valid", int'(out_valid), 1);
`ifdef WAVETABLE_LINEAR_INTERP_EN
        check("midpoint", int'($signed(sample_out)), 1500);
`else
        check("nearest", int'($signed(sample_out)), 1000);
`endif
        idle(1);
        check("mid_hold", int'($signed(sample_out)), last_out);

        step(0, 0, 0, 1, 4095, -100);
        step(0, 0, 0, 1, 0, 300);
        step(1, 4095, 'h40000, 0, 0, 0);
        idle(3);
`ifdef WAVETABLE_LINEAR_INTERP_EN
        check("wrap", int'($signed(sample_out)), 0);
`else
        check("wrap", int'($signed(sample_out)), -100);
`endif

        step(0, 0, 0, 1, 7, 10);
        step(0, 0, 0, 1, 8, 7);
        step(1, 7, 'h80000, 0, 0, 0);
        idle(3);
`ifdef WAVETABLE_LINEAR_INTERP_EN
        check("floor", int'($signed(sample_out)), 8);
`else
        check("floor", int'($signed(sample_out)), 10);
`endif

        step(1, 5, 0, 0, 0, 0);
        step(1, 5, 0, 1, 5, -5);
        idle(2);
        check("rf_old", int'($signed(sample_out)), 1000);
        idle(1);
        check("rf_new", int'($signed(sample_out)), -5);
        idle(2);

        for (int i = 0; i < 8; i++) step(1, int'($urandom_range(N - 1)), int'($urandom_range((1 << IW) - 1)), 0, 0, 0);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            bit we;
            we = ($urandom_range(7) == 0);
            step(bit'($urandom_range(3) != 0), int'($urandom_range(N - 1)), int'($urandom_range((1 << IW) - 1)),
                 we, int'($urandom_range(N - 1)), int'($urandom_range(65535)) - 32768);
        end
        idle(4);

        for (int i = 0; i < 3; i++) step(1, int'($urandom_range(N - 1)), int'($urandom_range((1 << IW) - 1)), 0, 0, 0);
        Reset_n = 0;
        in_valid = 0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_sample", int'($signed(sample_out)), 0);
        wt_we = 1;
        wt_waddr = AW'(9);
        wt_wdata = OW'(1234);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1;
        wt_we = 0;
        prime();
        idle(6);
        step(1, 9, 0, 0, 0, 0);
        idle(3);
        check("rst_no_write", int'($signed(sample_out)), mdl[9]);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
